lsf_seq: RTL and testbench

Multi-cycle logical left shifter for the ALU datapath. It is the left-shift counterpart of the combinational right-shift unit. It shifts operand `Rd1` left by `Rd2` positions, one bit per clock, under a start/busy/done handshake. It also reports a sticky overflow flag for any set bit shifted out of the MSB. The ALU control sequencer issues `start` and waits for `done` before writing `result` back.

---
 rtl/lsf_seq.sv | 152 +++++++++++++++
 tb/tb_lsf_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/lsf_seq.sv
// ---------------------------------------------------------------------------
// lsf_seq -- multi-cycle logical left shifter for the ALU datapath.
//
// The unit shifts Rd1 left by Rd2 positions at one bit per clock. A
// start/busy/done handshake controls it. A sticky overflow flag records any
// set bit that leaves the MSB. Shift amounts of WIDTH or more are clamped to
// WIDTH cycles, so the result is zero and ovf shows whether Rd1 was non-zero.
//
// Optional feature (compile-time macro LSF_ROTATE_EN):
//   defined   -> rotate left, unclamped count (0..2^WIDTH-1 cycles), ovf = 0
//   undefined -> logical shift with clamping and sticky ovf
//
// Ports:
//   clk     in   1      rising-edge clock
//   rst_n   in   1      asynchronous active-low reset
//   en      in   1      unit enable; low aborts an operation, gates start
//   start   in   1      request, sampled only in IDLE with en=1
//   Rd1     in   WIDTH  operand, captured on the accepted start
//   Rd2     in   WIDTH  unsigned shift amount, captured on the accepted start
//   result  out  WIDTH  registered shifted value
//   ovf     out  1      registered sticky OR of bits shifted out of the MSB
//   busy    out  1      high whenever the state is not IDLE
//   done    out  1      one-cycle pulse; result/ovf are final
// ---------------------------------------------------------------------------
module lsf_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] Rd1,
    input  logic [WIDTH-1:0] Rd2,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    // The counter holds the clamped value WIDTH in shift mode. In rotate mode
    // it holds any Rd2 value.
`ifdef LSF_ROTATE_EN
    localparam int CW = WIDTH;
`else
    localparam int CW = $clog2(WIDTH + 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] result_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;

    logic [CW-1:0]    k_d;       // cycle count for the operation being accepted
    logic [WIDTH-1:0] step_d;    // result after one more step
    logic             ovf_d;     // ovf after one more step

`ifdef LSF_ROTATE_EN
    assign k_d    = CW'(Rd2);
    assign step_d = {result_q[WIDTH-2:0], result_q[WIDTH-1]};
    assign ovf_d  = 1'b0;
`else
    localparam logic [WIDTH:0] WIDTH_V = (WIDTH + 1)'(WIDTH);

    // Clamp: shifting by WIDTH or more always clears the operand, so more
    // than WIDTH cycles would add nothing.
    assign k_d    = ({1'b0, Rd2} >= WIDTH_V) ? CW'(WIDTH) : CW'(Rd2);
    assign step_d = {result_q[WIDTH-2:0], 1'b0};
    assign ovf_d  = ovf_q | result_q[WIDTH-1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (en && start) begin
                        result_q <= Rd1;
                        ovf_q    <= 1'b0;
                        cnt_q    <= k_d;
                        busy_q   <= 1'b1;
                        // A zero-length operation skips SHIFT entirely.
                        if (k_d == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_SHIFT;
                        end
                    end
                end

                S_SHIFT: begin
                    if (!en) begin
                        // An aborted operation leaves no partial result.
                        state_q  <= S_IDLE;
                        result_q <= '0;
                        ovf_q    <= 1'b0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b0;
                    end else begin
                        result_q <= step_d;
                        ovf_q    <= ovf_d;
                        cnt_q    <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    // Leave unconditionally. A start seen here is dropped,
                    // which forces one idle cycle between operations.
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    if (!en) begin
                        result_q <= '0;
                        ovf_q    <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign result = result_q;
    assign ovf    = ovf_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_lsf_seq.sv
module tb_lsf_seq;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         start;
    logic [W-1:0] Rd1;
    logic [W-1:0] Rd2;
    logic [W-1:0] result;
    logic         ovf;
    logic         busy;
    logic         done;

    lsf_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .start  (start),
        .Rd1    (Rd1),
        .Rd2    (Rd2),
        .result (result),
        .ovf    (ovf),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    typedef struct {
        logic [W-1:0] res;
        logic         ov;
        int           cyc;
    } exp_t;
    exp_t exp_q[$];

    // Number of cycles the operation takes.
    function automatic int kof(input logic [W-1:0] b);
`ifdef LSF_ROTATE_EN
        return int'(b);
`else
        return (int'(b) >= W) ? W : int'(b);
`endif
    endfunction

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.cyc = 0;
`ifdef LSF_ROTATE_EN
        e.res = a;
        for (int i = 0; i < int'(b); i++) e.res = {e.res[W-2:0], e.res[W-1]};
        e.ov = 1'b0;
`else
        if (int'(b) >= W) begin
            e.res = '0;
            e.ov  = (a != '0);
        end else begin
            e.res = a << b;
            e.ov  = |(a >> (W - int'(b)));
        end
`endif
        return e;
    endfunction

    // Scoreboard consumer: each done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result", 32'(result), 32'(e.res));
                chk("ovf", 32'(ovf), 32'(e.ov));
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Issue one operation. If poke is set, start stays high and the operands
    // change for the whole busy period to show that they are ignored.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
        exp_t e;
        int   k, nb, nd;
        bit   ok;
        k = kof(b);
        e = model(a, b);
        @(posedge clk); #1;
        en = 1'b1; Rd1 = a; Rd2 = b; start = 1'b1;
        e.cyc = cyc + 1 + k;
        exp_q.push_back(e);
        @(posedge clk); #1;
        if (poke) begin
            Rd1 = ~a; Rd2 = 4'd1;
        end else begin
            start = 1'b0;
        end
        nb = 0; nd = 0; ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) nd++;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        start = 1'b0;
        chk("busy_bound", 32'(ok), 32'd1);
        chk("busy_cycles", 32'(nb), 32'(k + 1));
        chk("done_pulses", 32'(nd), 32'd1);
        chk("q_drain", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        chk("hold_result", 32'(result), 32'(e.res));
        chk("hold_ovf", 32'(ovf), 32'(e.ov));
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; start = 1'b0; Rd1 = '0; Rd2 = '0;
        #12;
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Reset asserted mid-SHIFT after one shift.
        @(posedge clk); #1;
        Rd1 = 4'b1111; Rd2 = 4'd3; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("midrst_result", 32'(result), 32'd0);
        chk("midrst_ovf", 32'(ovf), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        do_op(4'b0011, 4'd2, 1'b0);
        do_op(4'b1011, 4'd1, 1'b0);
        do_op(4'b0101, 4'd0, 1'b0);
        do_op(4'b1111, 4'd9, 1'b1);
        do_op(4'b1000, 4'd4, 1'b0);
        do_op(4'b0000, 4'd15, 1'b0);
`ifdef LSF_ROTATE_EN
        do_op(4'b1001, 4'd5, 1'b0);
`endif

        // en dropped after one shift: abort to IDLE with cleared outputs.
        @(posedge clk); #1;
        Rd1 = 4'b0110; Rd2 = 4'd3; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 en = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_ovf", 32'(ovf), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        // start with en low in IDLE is ignored.
        Rd1 = 4'b1001; Rd2 = 4'd1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("en0_busy", 32'(busy), 32'd0);
        chk("en0_result", 32'(result), 32'd0);
        en = 1'b1;

        for (int i = 0; i < 10; i++)
            do_op(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), bit'($urandom_range(0, 1)));

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
